// File: rtl/beat_buf_pkg.sv
// Shared constants for the ping-pong beat buffer: default geometry and the word
// driven on rd_data after an underrun when the last word is not held.
package beat_buf_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAddrW = 5;

  // Every bit of the underrun fill word takes this value.
  localparam logic UnderrunFillBit = 1'b0;

endpackage

// File: rtl/pingpong_bank_ram.sv
// One bank of the ping-pong buffer: simple dual-port RAM with a registered read port
// that holds its output when no read is requested.
module pingpong_bank_ram
  import beat_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;

  // No reset: contents survive resetn and flush.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pingpong_beat_buffer.sv
// Two-bank ping-pong buffer: a producer fills one bank while a beat-driven consumer
// drains the other; banks change hands only when completely written or read.
module pingpong_beat_buffer
  import beat_buf_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter bit          HOLD_LAST = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_tick,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_bank_o,
  output logic              swap,
  output logic              underrun
);

  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_valid_q, rd_valid_d;
  logic              swap_q, swap_d;
  logic              underrun_q, underrun_d;
  logic              rd_sel_q, rd_sel_d;    // bank whose RAM output feeds rd_data
  logic              rd_zero_q, rd_zero_d;  // rd_data forced to the fill word

  logic              wr_fire, rd_fire, rd_miss;
  logic              wr_last, rd_last;
  logic [DATA_W-1:0] rdata0, rdata1;

  assign wr_ready = ~full_q[wr_bank_q];

  // Reset and flush both suppress RAM traffic in the cycle they are applied.
  assign wr_fire = resetn & ~flush & wr_valid & wr_ready;
  assign rd_fire = resetn & ~flush & rd_tick & full_q[rd_bank_q];
  assign rd_miss = resetn & ~flush & rd_tick & ~full_q[rd_bank_q];
  assign wr_last = &wr_addr_q;
  assign rd_last = &rd_addr_q;

  always_comb begin
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    rd_valid_d = 1'b0;
    swap_d     = 1'b0;
    underrun_d = underrun_q;
    rd_sel_d   = rd_sel_q;
    rd_zero_d  = rd_zero_q;

    if (flush) begin
      full_d     = 2'b00;
      wr_bank_d  = 1'b0;
      rd_bank_d  = 1'b0;
      wr_addr_d  = '0;
      rd_addr_d  = '0;
      underrun_d = 1'b0;
    end else begin
      // Writer and reader never own the same bank, so both updates to full_d compose.
      if (wr_fire) begin
        wr_addr_d = wr_addr_q + ADDR_W'(1);
        if (wr_last) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end
      end
      if (rd_fire) begin
        rd_addr_d  = rd_addr_q + ADDR_W'(1);
        rd_valid_d = 1'b1;
        rd_sel_d   = rd_bank_q;
        rd_zero_d  = 1'b0;
        if (rd_last) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          swap_d            = 1'b1;
        end
      end
      if (rd_miss) begin
        underrun_d = 1'b1;
        if (!HOLD_LAST) begin
          rd_zero_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      full_q     <= 2'b00;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      swap_q     <= 1'b0;
      underrun_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      rd_valid_q <= rd_valid_d;
      swap_q     <= swap_d;
      underrun_q <= underrun_d;
      rd_sel_q   <= rd_sel_d;
      rd_zero_q  <= rd_zero_d;
    end
  end

  pingpong_bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bank0 (
    .clk     (clk),
    .we_i    (wr_fire & ~wr_bank_q),
    .waddr_i (wr_addr_q),
    .wdata_i (wr_data),
    .re_i    (rd_fire & ~rd_bank_q),
    .raddr_i (rd_addr_q),
    .rdata_o (rdata0)
  );

  pingpong_bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bank1 (
    .clk     (clk),
    .we_i    (wr_fire & wr_bank_q),
    .waddr_i (wr_addr_q),
    .wdata_i (wr_data),
    .re_i    (rd_fire & rd_bank_q),
    .raddr_i (rd_addr_q),
    .rdata_o (rdata1)
  );

  always_comb begin
    if (rd_zero_q) begin
      rd_data = {DATA_W{UnderrunFillBit}};
    end else if (rd_sel_q) begin
      rd_data = rdata1;
    end else begin
      rd_data = rdata0;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_bank_o = rd_bank_q;
  assign swap      = swap_q;
  assign underrun  = underrun_q;

endmodule
